// File: rtl/fsm_pkg.sv
// +----------------------------------------------------------------------+
// | fsm_pkg: shared state encoding and default sizing for one_run_stuffer |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package fsm_pkg;

  localparam int unsigned c_DATA_W_DEF  = 8;
  localparam int unsigned c_RUN_MAX_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STUFF = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/word_hold_buf.sv
// +----------------------------------------------------------------------+
// | word_hold_buf: one-word holding register with full flag              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module word_hold_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              unload_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o
);

  logic [DATA_W-1:0] data_q;
  logic              full_q;

  // A simultaneous load and unload leaves the buffer full with the new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

`default_nettype wire

// File: rtl/one_run_stuffer.sv
// +----------------------------------------------------------------------+
// | one_run_stuffer: LSB-first serialiser that inserts a 0 after RUN_MAX  |
// | consecutive 1s on the line.  Revision: 1.0                            |
// +----------------------------------------------------------------------+
`default_nettype none

module one_run_stuffer
  import fsm_pkg::*;
#(
  parameter int unsigned DATA_W  = c_DATA_W_DEF,
  parameter int unsigned RUN_MAX = c_RUN_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              stuffed,
  output logic              word_done,
  output logic              busy
);

  localparam int unsigned c_CNT_W = $clog2(DATA_W + 1);
  localparam logic [c_CNT_W-1:0] c_WORD_BITS = c_CNT_W'(DATA_W);
  localparam logic [2:0]         c_RUN_LIM   = 3'(RUN_MAX);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [c_CNT_W-1:0]  left_q, left_d;
  logic [2:0]          run_q, run_d;
  logic                bit_q, bit_d;
  logic                bv_q, bv_d;
  logic                stf_q, stf_d;
  logic                wd_q, wd_d;

  logic                w_hold_full;
  logic [DATA_W-1:0]   w_hold_data;
  logic                w_unload;
  logic                w_load_sh;
  logic [2:0]          w_run_inc;

  assign in_ready = ~w_hold_full;

  word_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load_i   (in_valid & ~w_hold_full),
    .data_i   (in_data),
    .unload_i (w_unload),
    .data_o   (w_hold_data),
    .full_o   (w_hold_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      left_q  <= '0;
      run_q   <= '0;
      bit_q   <= 1'b0;
      bv_q    <= 1'b0;
      stf_q   <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      left_q  <= left_d;
      run_q   <= run_d;
      bit_q   <= bit_d;
      bv_q    <= bv_d;
      stf_q   <= stf_d;
      wd_q    <= wd_d;
    end
  end

  // The state names the bit being registered onto the line at the next edge.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    left_d    = left_q;
    run_d     = run_q;
    bit_d     = 1'b0;
    bv_d      = 1'b0;
    stf_d     = 1'b0;
    wd_d      = 1'b0;
    w_load_sh = 1'b0;
    w_run_inc = run_q + 3'd1;

    case (state_q)
      ST_IDLE: begin
        run_d = '0;
        if (w_hold_full) begin
          w_load_sh = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_d  = sh_q[0];
        bv_d   = 1'b1;
        wd_d   = (left_q == c_CNT_W'(1));
        sh_d   = sh_q >> 1;
        left_d = left_q - c_CNT_W'(1);
        run_d  = sh_q[0] ? w_run_inc : 3'd0;
        // A due stuff takes priority over chaining into the next word.
        if (sh_q[0] && (w_run_inc == c_RUN_LIM)) begin
          state_d = ST_STUFF;
        end else if (wd_d) begin
          if (w_hold_full) w_load_sh = 1'b1;
          else             state_d   = ST_IDLE;
        end
      end
      ST_STUFF: begin
        bv_d  = 1'b1;
        stf_d = 1'b1;
        run_d = '0;
        if (left_q != '0) begin
          state_d = ST_SHIFT;
        end else if (w_hold_full) begin
          w_load_sh = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_load_sh) begin
      sh_d   = w_hold_data;
      left_d = c_WORD_BITS;
    end
  end

  assign w_unload  = w_load_sh;
  assign bit_out   = bit_q;
  assign bit_valid = bv_q;
  assign stuffed   = stf_q;
  assign word_done = wd_q;
  assign busy      = (state_q != ST_IDLE) | w_hold_full;

endmodule

`default_nettype wire

// File: tb/tb_one_run_stuffer.sv
// +----------------------------------------------------------------------+
// | tb_one_run_stuffer: scoreboard bench for one_run_stuffer              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_one_run_stuffer;

  localparam int RUN_MAX = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data, in_data1;
  logic       in_valid, in_valid1;
  logic       in_ready, bit_out, bit_valid, stuffed, word_done, busy;
  logic       in_ready1, bit_out1, bit_valid1, stuffed1, word_done1, busy1;

  always #5 clk = ~clk;

  one_run_stuffer #(.DATA_W(8), .RUN_MAX(RUN_MAX)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .stuffed(stuffed), .word_done(word_done), .busy(busy)
  );

  one_run_stuffer #(.DATA_W(8), .RUN_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .bit_out(bit_out1), .bit_valid(bit_valid1),
    .stuffed(stuffed1), .word_done(word_done1), .busy(busy1)
  );

  typedef struct packed {logic b; logic s; logic wd;} exp_t;

  exp_t expq[$];
  logic dataq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rand_mode = 1'b0;
  int   nbits = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  int   acc_cyc = 0;
  int   run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pattern chars: '0'/'1' data bits, 's' stuffed 0; word_done on the last data char.
  task automatic push_str(input string p);
    int lastd = -1;
    for (int i = 0; i < p.len(); i++) if (p[i] != "s") lastd = i;
    for (int i = 0; i < p.len(); i++) begin
      if (p[i] == "s") expq.push_back('{b: 1'b0, s: 1'b1, wd: 1'b0});
      else             expq.push_back('{b: (p[i] == "1"), s: 1'b0, wd: (i == lastd)});
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] d, input string pat);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    if (rand_mode) for (int i = 0; i < 8; i++) dataq.push_back(d[i]);
    else           push_str(pat);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((expq.size() != 0 || dataq.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    @(negedge clk);
    chk({name, "_left"}, expq.size() + dataq.size(), 0);
    chk({name, "_idle_valid"}, bit_valid, 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_ready"}, in_ready, 1);
  endtask

  // Monitor: pops the scoreboard on every valid line bit.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bit_valid) begin
        nbits++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (!rand_mode) begin
          if (expq.size() == 0) chk("unexpected_bit", 1, 0);
          else begin
            e = expq.pop_front();
            chk("line_bit", {bit_out, stuffed, word_done}, e);
          end
        end else begin
          chk("stuff_rule", stuffed, (run == RUN_MAX));
          if (stuffed) begin
            chk("stuff_zero", {bit_out, word_done}, 0);
            run = 0;
          end else begin
            if (dataq.size() == 0) chk("rand_extra", 1, 0);
            else                   chk("rand_data", bit_out, dataq.pop_front());
            run = bit_out ? run + 1 : 0;
          end
        end
      end else if (rand_mode) begin
        if (run == RUN_MAX) chk("missing_stuff", run, 0);
        run = 0;
      end
    end
  end

  initial begin
    string p1;
    int    n;
    in_data   = '0;
    in_valid  = 1'b0;
    in_data1  = '0;
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bit_out, bit_valid, stuffed, word_done, busy}, 0);
    chk("reset_ready", in_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    first_cyc = -1; nbits = 0;
    send(8'h00, "00000000");
    drain("w00");
    chk("w00_latency", first_cyc - acc_cyc, 2);
    chk("w00_count", nbits, 8);

    nbits = 0;
    send(8'hFF, "11s11s11s11s");
    drain("wFF");
    chk("wFF_count", nbits, 12);

    first_cyc = -1; nbits = 0;
    send(8'h80, "00000001");
    send(8'h01, "1s0000000");
    drain("b2b");
    chk("b2b_span", last_cyc - first_cyc + 1, 17);
    chk("b2b_count", nbits, 17);

    chk("rm1_ready", in_ready1, 1);
    in_data1  = 8'hB6;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    p1 = "01s1s01s1s01s";
    n  = 0;
    for (int t = 0; t < 40; t++) begin
      if (bit_valid1) begin
        if (n < 13) chk($sformatf("rm1_bit%0d", n), {bit_out1, stuffed1, word_done1},
                        {(p1[n] == "1"), (p1[n] == "s"), (n == 11)});
        n++;
      end
      @(negedge clk);
    end
    chk("rm1_count", n, 13);

    nbits = 0;
    send(8'hFF, "11s11s11s11s");
    send(8'h55, "");
    for (int t = 0; t < 50 && nbits < 3; t++) @(negedge clk);
    chk("rst_mid_bits", nbits, 3);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_outputs", {bit_out, bit_valid, stuffed, word_done, busy}, 0);
    chk("rst_mid_ready", in_ready, 1);
    expq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    nbits = 0;
    send(8'h0F, "11s11s0000");
    drain("after_rst");
    chk("after_rst_count", nbits, 10);

    rand_mode = 1'b1;
    run = 0;
    for (int w = 0; w < 1500; w++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) d = d | 8'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
      send(d, "");
    end
    drain("rand");
    rand_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
